// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and transfer encoding for the single-clock decoupled FIFO.
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    XFER_NONE = 2'b00,
    XFER_POP  = 2'b01,
    XFER_PUSH = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

  // Address bits plus one wrap bit, so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read for fall-through output.
module fifo_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_decoupled.sv
// Single-clock ready/valid FIFO with per-port enables, occupancy count,
// almost-full/empty thresholds, synchronous flush and sticky overflow.
module sync_fifo_decoupled
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned AFULL_THRESH  = DEPTH - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                          io_clock,
  input  logic                          io_reset_n,
  input  logic                          io_wr_valid,
  output logic                          io_wr_ready,
  input  logic [WIDTH-1:0]              io_wr_bits,
  input  logic                          io_wr_enable,
  output logic                          io_rd_valid,
  input  logic                          io_rd_ready,
  output logic [WIDTH-1:0]              io_rd_bits,
  input  logic                          io_rd_enable,
  input  logic                          io_flush,
  output logic [count_width(DEPTH)-1:0] io_count,
  output logic                          io_almost_full,
  output logic                          io_almost_empty,
  output logic                          io_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_depth_check
    $error("sync_fifo_decoupled: DEPTH must be a power of two >= 2");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          empty;
  logic          full;
  logic          wr_fire;
  logic          rd_fire;
  xfer_e         xfer;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign io_wr_ready = io_wr_enable && !full;
  assign io_rd_valid = io_rd_enable && !empty;

  // Handshakes still report from pre-flush state, but a flush cancels both transfers.
  assign wr_fire = io_wr_valid && io_wr_ready && !io_flush;
  assign rd_fire = io_rd_valid && io_rd_ready && !io_flush;
  assign xfer    = xfer_e'({wr_fire, rd_fire});

  always_ff @(posedge io_clock or negedge io_reset_n) begin
    if (!io_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (io_flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case (xfer)
        XFER_PUSH: count_q <= count_q + CW'(1);
        XFER_POP:  count_q <= count_q - CW'(1);
        default:   count_q <= count_q;
      endcase
      if (io_wr_valid && io_wr_enable && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign io_count        = count_q;
  assign io_almost_full  = (32'(count_q) >= AFULL_THRESH);
  assign io_almost_empty = (32'(count_q) <= AEMPTY_THRESH);
  assign io_overflow     = overflow_q;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clock   (io_clock),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (io_wr_bits),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (io_rd_bits)
  );

endmodule

// File: tb/tb_sync_fifo_decoupled.sv
// Directed vector-table bench for sync_fifo_decoupled at WIDTH=8, DEPTH=8.
module tb_sync_fifo_decoupled;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, wr_ready, wr_enable;
  logic [7:0] wr_bits;
  logic       rd_valid, rd_ready, rd_enable;
  logic [7:0] rd_bits;
  logic       flush;
  logic [3:0] count;
  logic       almost_full, almost_empty, overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_decoupled #(
    .WIDTH (8),
    .DEPTH (8)
  ) dut (
    .io_clock        (clk),
    .io_reset_n      (rst_n),
    .io_wr_valid     (wr_valid),
    .io_wr_ready     (wr_ready),
    .io_wr_bits      (wr_bits),
    .io_wr_enable    (wr_enable),
    .io_rd_valid     (rd_valid),
    .io_rd_ready     (rd_ready),
    .io_rd_bits      (rd_bits),
    .io_rd_enable    (rd_enable),
    .io_flush        (flush),
    .io_count        (count),
    .io_almost_full  (almost_full),
    .io_almost_empty (almost_empty),
    .io_overflow     (overflow)
  );

  typedef struct {
    logic       wv;
    logic [7:0] wb;
    logic       we;
    logic       rr;
    logic       re;
    logic       fl;
    logic       x_wrdy;
    logic       x_rvld;
    logic [7:0] x_bits;
    logic [3:0] x_cnt;
    logic       x_af;
    logic       x_ae;
    logic       x_ovf;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] model[$];

  // Almost flags follow from the count with AFULL=4 and AEMPTY=4 at DEPTH=8.
  function automatic vec_t mk(input int wv, input int wb, input int we, input int rr,
                              input int re, input int fl, input int xw, input int xr,
                              input int xb, input int xc, input int xo);
    vec_t v;
    v.wv = wv[0]; v.wb = wb[7:0]; v.we = we[0]; v.rr = rr[0]; v.re = re[0]; v.fl = fl[0];
    v.x_wrdy = xw[0]; v.x_rvld = xr[0]; v.x_bits = xb[7:0]; v.x_cnt = xc[3:0];
    v.x_af = (xc >= 4); v.x_ae = (xc <= 4); v.x_ovf = xo[0];
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [7:0] wb, input logic we,
                       input logic rr, input logic re, input logic fl);
    wr_valid = wv; wr_bits = wb; wr_enable = we; rd_ready = rr; rd_enable = re; flush = fl;
  endtask

  task automatic run_row(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.wv, v.wb, v.we, v.rr, v.re, v.fl);
    #1;
    chk("wr_ready", idx, 32'(wr_ready), 32'(v.x_wrdy));
    chk("rd_valid", idx, 32'(rd_valid), 32'(v.x_rvld));
    if (v.x_rvld) chk("rd_bits", idx, 32'(rd_bits), 32'(v.x_bits));
    chk("count", idx, 32'(count), 32'(v.x_cnt));
    chk("almost_full", idx, 32'(almost_full), 32'(v.x_af));
    chk("almost_empty", idx, 32'(almost_empty), 32'(v.x_ae));
    chk("overflow", idx, 32'(overflow), 32'(v.x_ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // fill to full, one refused beat sets overflow
    for (int k = 0; k < 8; k++) tbl.push_back(mk(1, k, 1, 0, 0, 0, 1, 0, 0, k, 0));
    tbl.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 8, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 8, 1));
    // drain in order
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, k, 8 - k, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    // write with port disabled must not be accepted
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 10; k++) tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    // read port disabled holds data
    tbl.push_back(mk(1, 'hA5, 1, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 1, 'hA5, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 1));
    // fill 5, flush with simultaneous write and read
    for (int k = 0; k < 5; k++) tbl.push_back(mk(1, 'h10 + k, 1, 0, 0, 0, 1, 0, 0, k, 1));
    tbl.push_back(mk(1, 'h99, 1, 1, 1, 1, 1, 1, 'h10, 5, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0));

    repeat (15) @(negedge clk);
    #1;
    chk("rst_wr_ready", 0, 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 0, 32'(rd_valid), 32'd0);
    chk("rst_count", 0, 32'(count), 32'd0);
    chk("rst_almost_empty", 0, 32'(almost_empty), 32'd1);
    chk("rst_almost_full", 0, 32'(almost_full), 32'd0);
    chk("rst_overflow", 0, 32'(overflow), 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) run_row(tbl[i], i);

    // streaming across pointer wraps with constant occupancy
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 8'(8'h40 + k), 1'b1, 1'b0, 1'b0, 1'b0);
      model.push_back(8'(8'h40 + k));
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'b1, 8'(8'h50 + i), 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      chk("stream_rd_valid", i, 32'(rd_valid), 32'd1);
      chk("stream_wr_ready", i, 32'(wr_ready), 32'd1);
      chk("stream_rd_bits", i, 32'(rd_bits), 32'(model[0]));
      chk("stream_count", i, 32'(count), 32'd3);
      void'(model.pop_front());
      model.push_back(8'(8'h50 + i));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      chk("drain_rd_bits", i, 32'(rd_bits), 32'(model[0]));
      void'(model.pop_front());
    end
    @(negedge clk);
    #1;
    chk("drain_rd_valid", 0, 32'(rd_valid), 32'd0);
    chk("drain_count", 0, 32'(count), 32'd0);

    // full: concurrent read fires, write refused and flagged
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(1'b1, 8'(8'h60 + k), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("full_wr_ready", 0, 32'(wr_ready), 32'd0);
    chk("full_rd_bits", 0, 32'(rd_bits), 32'h60);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("full_rw_count", 0, 32'(count), 32'd7);
    chk("full_rw_overflow", 0, 32'(overflow), 32'd1);
    chk("full_rw_next_bits", 0, 32'(rd_bits), 32'h61);

    // asynchronous reset between edges
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 0, 32'(count), 32'd0);
    chk("arst_rd_valid", 0, 32'(rd_valid), 32'd0);
    chk("arst_overflow", 0, 32'(overflow), 32'd0);
    chk("arst_almost_empty", 0, 32'(almost_empty), 32'd1);
    chk("arst_wr_ready", 0, 32'(wr_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("post_rst_wr_ready", 0, 32'(wr_ready), 32'd1);
    chk("post_rst_rd_valid", 0, 32'(rd_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
